// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external single-port memory between IF fetches and MEM loads/stores.
// Optional ARB_ROUND_ROBIN_EN alternates grants under contention; default is fixed MEM-over-IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_ack
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] IF_ACC   = 3'd1;
    localparam logic [2:0] MEM_ACC  = 3'd2;
    localparam logic [2:0] IF_DONE  = 3'd3;
    localparam logic [2:0] MEM_DONE = 3'd4;
    logic [2:0] state;
    logic       mem_pend;
    logic       grant_mem;
    assign mem_pend = mem_r_en | mem_w_en;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    // last_grant: 1 = MEM, 0 = IF; under contention the other side wins
    assign grant_mem = mem_pend & (~if_req | ~last_grant);
`else
    assign grant_mem = mem_pend;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        ext_addr  <= mem_addr;
                        ext_wdata <= mem_wdata;
                        ext_we    <= mem_w_en;
                        ext_req   <= 1'b1;
                        state     <= MEM_ACC;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b1;
`endif
                    end else if (if_req) begin
                        ext_addr <= if_addr;
                        ext_we   <= 1'b0;
                        ext_req  <= 1'b1;
                        state    <= IF_ACC;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b0;
`endif
                    end
                end
                IF_ACC: begin
                    if (ext_ack) begin
                        ext_req  <= 1'b0;
                        if_rdata <= ext_rdata;
                        if_ready <= 1'b1;
                        state    <= IF_DONE;
                    end
                end
                MEM_ACC: begin
                    if (ext_ack) begin
                        ext_req   <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= MEM_DONE;
                        if (!ext_we) mem_rdata <= ext_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven transactions with a ready/data scoreboard plus contention, reset-abort, flush and spurious-ack sequences.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0, ext_ack = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ext_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, ext_addr, ext_wdata;
    logic        if_ready, mem_ready, ext_req, ext_we;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem_model = '0;
    logic [31:0] if_model = '0;

    typedef struct {
        logic        is_mem;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        flush;
    } vec_t;
    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } exp_t;
    vec_t vecs[6];
    exp_t sb[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v);
        if (v.is_mem) begin
            mem_r_en = v.rd; mem_w_en = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
    endtask

    task automatic serve(input vec_t v);
        bit   ok = 0;
        exp_t e;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ext_req;
        end
        check("grant_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("ext_addr", ext_addr, v.addr);
        check("ext_we", 32'(ext_we), 32'(v.is_mem & v.wr));
        if (v.is_mem && v.wr) check("ext_wdata", ext_wdata, v.wdata);
        if (v.flush) if_req = 1'b0;
        repeat (v.dly) begin
            @(negedge clk);
            check("req_held", 32'(ext_req), 32'd1);
            check("no_early_ready", 32'(if_ready | mem_ready), 32'd0);
        end
        e.is_mem = v.is_mem;
        e.data   = (v.is_mem && v.wr) ? mem_model : v.rdata;
        if (v.is_mem && !v.wr) mem_model = v.rdata;
        if (!v.is_mem) if_model = v.rdata;
        sb.push_back(e);
        ext_ack = 1'b1; ext_rdata = v.rdata;
        @(negedge clk);
        ext_ack = 1'b0; ext_rdata = $urandom;
        check("req_low_done", 32'(ext_req), 32'd0);
        e = sb.pop_front();
        check(e.is_mem ? "mem_ready" : "if_ready", 32'(e.is_mem ? mem_ready : if_ready), 32'd1);
        check("other_ready", 32'(e.is_mem ? if_ready : mem_ready), 32'd0);
        check(e.is_mem ? "mem_rdata" : "if_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
        if (v.is_mem) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end else if_req = 1'b0;
        @(negedge clk);
        check("ready_pulse_end", 32'(if_ready | mem_ready), 32'd0);
        check("idle_gap", 32'(ext_req), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_req(v);
        serve(v);
    endtask

    initial begin
        vec_t c_mem, c_if, f, a;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h400, 32'h12345678, 32'h55555555, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h800, 32'h0,        32'hCAFEF00D, 2, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h404, 32'hA5A5A5A5, 32'h77777777, 1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h14,  32'h0,        32'h00000013, 3, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        32'hFFFFFFFF, 0, 1'b0};
        #1;
        check("rst_ext_req", 32'(ext_req), 32'd0);
        check("rst_ext_we", 32'(ext_we), 32'd0);
        check("rst_ext_addr", ext_addr, 32'd0);
        check("rst_ext_wdata", ext_wdata, 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // contention after a MEM grant
        c_mem = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 0, 1'b0};
        c_if  = '{1'b0, 1'b0, 1'b0, 32'h4,  32'h0, 32'h600DC0DE, 0, 1'b0};
        @(negedge clk);
        drive_req(c_mem);
        drive_req(c_if);
`ifdef ARB_ROUND_ROBIN_EN
        serve(c_if);
        serve(c_mem);
`else
        serve(c_mem);
        serve(c_if);
`endif

        // asynchronous reset during a MEM access
        a = '{1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h12121212, 0, 1'b0};
        @(negedge clk);
        drive_req(a);
        @(negedge clk);
        @(negedge clk);
        check("abort_req_before", 32'(ext_req), 32'd1);
        #2 rst = 1'b0;
        #1 check("abort_req_async", 32'(ext_req), 32'd0);
        mem_r_en = 1'b0;
        mem_model = '0;
        if_model = '0;
        ext_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ready", 32'(mem_ready | if_ready), 32'd0);
        end
        ext_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_ready_after", 32'(mem_ready | if_ready), 32'd0);
        run_vec(vecs[0]);

        // fetch flushed mid-access still completes with one pulse
        f = '{1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'hF1F1F1F1, 2, 1'b1};
        run_vec(f);
        repeat (3) begin
            @(negedge clk);
            check("flush_stays_idle", 32'(ext_req), 32'd0);
        end

        // spurious ack in IDLE
        ext_ack = 1'b1; ext_rdata = 32'h99999999;
        repeat (3) begin
            @(negedge clk);
            check("spur_no_ready", 32'(if_ready | mem_ready), 32'd0);
            check("spur_no_req", 32'(ext_req), 32'd0);
        end
        ext_ack = 1'b0;
        check("spur_if_rdata", if_rdata, if_model);
        check("spur_mem_rdata", mem_rdata, mem_model);
        run_vec(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
